led_cmd_parser: RTL and testbench
=================================

// Module: led_cmd_parser
// PURPOSE
//  Upstream stage of the LED controller: consumes bytes from the UART receiver, parses 3-byte
//  frames {CMD, DATA, CHK} and drives the controller's sel[1:0]/data[7:0] inputs from registers.
//  Outputs change only on a fully validated frame; bad or incomplete frames leave them unchanged
//  and report an error. Inter-byte timeout recovers the parser from a lost byte.
// PARAMETERS
//  TIMEOUT_CYCLES  10_000_000  max clk cycles between bytes of one frame (100 ms @ 100 MHz), >=2
//  CMD_MARKER      4'h5        required value of CMD[7:4]
// PORTS
//  clk        in   1  system clock, all logic on rising edge
//  reset_n    in   1  asynchronous, active-low reset
//  rx_data    in   8  received byte, valid only when rx_valid=1
//  rx_valid   in   1  one-cycle strobe from UART RX; no backpressure, every strobe is consumed
//  sel        out  2  mode select to LED controller (registered)
//  data       out  8  LED pattern to LED controller (registered)
//  update     out  1  one-cycle pulse, cycle after sel/data take new values
//  busy       out  1  1 while a frame is partially received (state != IDLE)
//  err        out  1  one-cycle pulse on any frame error
//  err_code   out  2  01 bad marker, 10 bad checksum, 11 timeout; sticky, cleared to 00 on good frame
// BEHAVIOUR
//  Reset (async, reset_n=0): state=IDLE, sel=2'b00, data=8'h00, update=0, busy=0, err=0,
//   err_code=2'b00, timeout counter=0, captured CMD/DATA=0. Reset mid-frame aborts the frame.
//  FSM states: IDLE, GET_DATA, GET_CHK.
//   IDLE: rx_valid & rx_data[7:4]==CMD_MARKER -> latch cmd=rx_data, go GET_DATA.
//         rx_valid & marker mismatch -> stay IDLE, err=1, err_code=01.
//   GET_DATA: rx_valid -> latch dat=rx_data, go GET_CHK.
//   GET_CHK: rx_valid & rx_data==(cmd ^ dat) -> commit sel<=cmd[1:0], data<=dat,
//            err_code<=00, go IDLE; update=1 the following cycle.
//            rx_valid & mismatch -> go IDLE, err=1, err_code=10, sel/data unchanged.
//  Timeout: counter cleared on entering GET_DATA/GET_CHK and on every accepted byte; increments
//   each cycle in GET_DATA/GET_CHK without rx_valid. When it would reach TIMEOUT_CYCLES -> go IDLE,
//   err=1, err_code=11, counter=0. Width = $clog2(TIMEOUT_CYCLES+1), no wrap.
//  Simultaneous rx_valid and timeout in same cycle: byte wins, timeout does not fire.
//  Byte arriving in the same cycle as timeout-to-IDLE is not possible (byte wins); the first byte
//   after a timeout is evaluated as a CMD in IDLE.
//  Back-to-back rx_valid on consecutive cycles must be handled (one byte per cycle).
//  cmd[3:2] ignored. sel=00/01 is a valid commit (controller blanks LEDs); no special casing.
//  Latency: CHK byte at cycle N -> sel/data new at N+1, update=1 at N+1.
//  err and update are never asserted in the same cycle; busy=0 on the cycle sel/data update.
// TESTING (bench uses TIMEOUT_CYCLES=16)
//  1 Reset: hold reset_n=0, drive rx traffic -> sel=00, data=00, busy=0, err_code=00, no pulses.
//  2 Good frame 8'h52,8'h3C,8'h6E -> sel=10, data=3C, one update pulse, err never set.
//  3 Bad checksum 8'h53,8'hFF,8'h00 after test 2 -> err pulse, err_code=10, sel=10/data=3C held.
//  4 Bad marker 8'hA3 in IDLE -> err pulse, err_code=01, busy stays 0; then 8'h53,8'h81,8'hD2
//    -> sel=11, data=81, err_code=00.
//  5 Timeout: 8'h52 then idle 16 cycles -> err pulse, err_code=11, busy=0; byte on cycle 15 instead
//    -> no timeout, frame continues.
//  6 Reset_n pulsed low between DATA and CHK -> all outputs at reset values; later CHK byte alone
//    treated as CMD (marker check).

Source files
------------

// File: rtl/led_cmd_parser.sv
// rtl/led_cmd_parser.sv - parses {CMD, DATA, CHK} byte frames from the UART into LED sel/data registers
module led_cmd_parser #(
  parameter int unsigned TIMEOUT_CYCLES = 10_000_000,
  parameter logic [3:0]  CMD_MARKER     = 4'h5
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  output logic [1:0] sel,
  output logic [7:0] data,
  output logic       update,
  output logic       busy,
  output logic       err,
  output logic [1:0] err_code
);

  localparam int unsigned    CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    GET_DATA = 2'd1,
    GET_CHK  = 2'd2
  } state_t;

  state_t           state;
  logic [7:0]       cmd;
  logic [7:0]       dat;
  logic [CNT_W-1:0] tcnt;
  logic             timeout_hit;

  // The next idle cycle would make the gap TIMEOUT_CYCLES long.
  assign timeout_hit = (tcnt == CNT_LAST);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      cmd      <= 8'h00;
      dat      <= 8'h00;
      tcnt     <= '0;
      sel      <= 2'b00;
      data     <= 8'h00;
      update   <= 1'b0;
      busy     <= 1'b0;
      err      <= 1'b0;
      err_code <= 2'b00;
    end else begin
      update <= 1'b0;
      err    <= 1'b0;
      if (state != IDLE && !rx_valid) begin
        // A received byte always takes priority over the timeout.
        if (timeout_hit) begin
          state    <= IDLE;
          busy     <= 1'b0;
          tcnt     <= '0;
          err      <= 1'b1;
          err_code <= 2'b11;
        end else begin
          tcnt <= tcnt + 1'b1;
        end
      end else begin
        case (state)
          IDLE: begin
            if (rx_valid) begin
              if (rx_data[7:4] == CMD_MARKER) begin
                cmd   <= rx_data;
                state <= GET_DATA;
                busy  <= 1'b1;
                tcnt  <= '0;
              end else begin
                err      <= 1'b1;
                err_code <= 2'b01;
              end
            end
          end
          GET_DATA: begin
            dat   <= rx_data;
            state <= GET_CHK;
            tcnt  <= '0;
          end
          GET_CHK: begin
            state <= IDLE;
            busy  <= 1'b0;
            tcnt  <= '0;
            if (rx_data == (cmd ^ dat)) begin
              sel      <= cmd[1:0];
              data     <= dat;
              err_code <= 2'b00;
              update   <= 1'b1;
            end else begin
              err      <= 1'b1;
              err_code <= 2'b10;
            end
          end
          default: begin
            state <= IDLE;
            busy  <= 1'b0;
            tcnt  <= '0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_led_cmd_parser.sv
// tb/tb_led_cmd_parser.sv - randomized frame traffic against a queue-based frame model
module tb_led_cmd_parser;

  localparam int T = 16;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic       rx_valid = 1'b0;
  logic [1:0] sel;
  logic [7:0] data;
  logic       update;
  logic       busy;
  logic       err;
  logic [1:0] err_code;

  int n_checks = 0;
  int n_fail = 0;

  led_cmd_parser #(.TIMEOUT_CYCLES(T), .CMD_MARKER(4'h5)) dut (
    .clk(clk), .reset_n(reset_n), .rx_data(rx_data), .rx_valid(rx_valid),
    .sel(sel), .data(data), .update(update), .busy(busy), .err(err), .err_code(err_code)
  );

  always #5 clk = ~clk;

  // Frame model: bytes of the frame in progress plus the idle gap since the last byte.
  logic [7:0] q[$];
  int         idle = 0;
  logic [1:0] m_sel = 2'b00;
  logic [7:0] m_data = 8'h00;
  logic       m_update = 1'b0;
  logic       m_busy = 1'b0;
  logic       m_err = 1'b0;
  logic [1:0] m_code = 2'b00;

  always @(posedge clk) begin
    if (!reset_n) begin
      q.delete();
      idle <= 0;
      m_sel <= 2'b00; m_data <= 8'h00; m_update <= 1'b0;
      m_busy <= 1'b0; m_err <= 1'b0; m_code <= 2'b00;
    end else begin
      m_update <= 1'b0;
      m_err <= 1'b0;
      if (rx_valid) begin
        idle <= 0;
        if (q.size() == 0) begin
          if (rx_data[7:4] == 4'h5) begin
            q.push_back(rx_data);
            m_busy <= 1'b1;
          end else begin
            m_err <= 1'b1; m_code <= 2'b01;
          end
        end else if (q.size() == 1) begin
          q.push_back(rx_data);
        end else begin
          if (rx_data == (q[0] ^ q[1])) begin
            m_sel <= q[0][1:0]; m_data <= q[1]; m_update <= 1'b1; m_code <= 2'b00;
          end else begin
            m_err <= 1'b1; m_code <= 2'b10;
          end
          q.delete();
          m_busy <= 1'b0;
        end
      end else if (q.size() != 0) begin
        if (idle + 1 == T) begin
          q.delete();
          idle <= 0;
          m_busy <= 1'b0; m_err <= 1'b1; m_code <= 2'b11;
        end else begin
          idle <= idle + 1;
        end
      end
    end
  end

  always @(negedge clk) begin
    n_checks++;
    if ({sel, data, update, busy, err, err_code} !==
        {m_sel, m_data, m_update, m_busy, m_err, m_code}) begin
      n_fail++;
      $display("FAIL cycle_cmp t=%0t dut sel=%b data=%h upd=%b busy=%b err=%b code=%b, model sel=%b data=%h upd=%b busy=%b err=%b code=%b",
               $time, sel, data, update, busy, err, err_code,
               m_sel, m_data, m_update, m_busy, m_err, m_code);
    end
  end

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic cyc(input logic v, input logic [7:0] b);
    @(negedge clk);
    #1;
    rx_valid = v;
    rx_data = b;
  endtask

  task automatic send(input logic [7:0] b);
    cyc(1'b1, b);
  endtask

  task automatic gap(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 8'($urandom));
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    #1;
    reset_n = 1'b0;
    rx_valid = 1'($urandom);
    rx_data = 8'($urandom);
    @(negedge clk);
    #1;
    reset_n = 1'b1;
    rx_valid = 1'b0;
  endtask

  initial begin
    logic [7:0] c, d, b;
    int kind;

    // Reset held with traffic present.
    for (int i = 0; i < 6; i++) cyc(1'($urandom), 8'h50 | 8'($urandom_range(0, 15)));
    chk("rst_sel", {6'd0, sel}, 8'h00);
    chk("rst_data", data, 8'h00);
    chk("rst_busy", {7'd0, busy}, 8'h00);
    chk("rst_code", {6'd0, err_code}, 8'h00);
    chk("rst_pulses", {6'd0, update, err}, 8'h00);
    @(negedge clk); #1; reset_n = 1'b1; rx_valid = 1'b0;

    // Good frame.
    send(8'h52); send(8'h3C); send(8'h6E); cyc(1'b0, 8'h00);
    chk("good_sel", {6'd0, sel}, 8'h02);
    chk("good_data", data, 8'h3C);
    chk("good_update", {7'd0, update}, 8'h01);
    chk("good_err", {7'd0, err}, 8'h00);
    chk("model_good_data", m_data, 8'h3C);

    // Bad checksum holds previous outputs.
    send(8'h53); send(8'hFF); send(8'h00); cyc(1'b0, 8'h00);
    chk("badchk_err", {7'd0, err}, 8'h01);
    chk("badchk_code", {6'd0, err_code}, 8'h02);
    chk("badchk_sel", {6'd0, sel}, 8'h02);
    chk("badchk_data", data, 8'h3C);

    // Bad marker, then a good frame clears err_code.
    send(8'hA3); cyc(1'b0, 8'h00);
    chk("badmark_err", {7'd0, err}, 8'h01);
    chk("badmark_code", {6'd0, err_code}, 8'h01);
    chk("badmark_busy", {7'd0, busy}, 8'h00);
    send(8'h53); send(8'h81); send(8'hD2); cyc(1'b0, 8'h00);
    chk("good2_sel", {6'd0, sel}, 8'h03);
    chk("good2_data", data, 8'h81);
    chk("good2_code", {6'd0, err_code}, 8'h00);
    chk("model_good2_sel", {6'd0, m_sel}, 8'h03);

    // Timeout after 16 idle cycles.
    send(8'h52); gap(16);
    chk("to_not_yet_busy", {7'd0, busy}, 8'h01);
    cyc(1'b0, 8'h00);
    chk("to_err", {7'd0, err}, 8'h01);
    chk("to_code", {6'd0, err_code}, 8'h03);
    chk("to_busy", {7'd0, busy}, 8'h00);
    chk("model_to_code", {6'd0, m_code}, 8'h03);

    // Byte on the last allowed cycle keeps the frame alive.
    send(8'h52); gap(15); send(8'h11); send(8'h43); cyc(1'b0, 8'h00);
    chk("edge_sel", {6'd0, sel}, 8'h02);
    chk("edge_data", data, 8'h11);
    chk("edge_update", {7'd0, update}, 8'h01);
    chk("edge_code", {6'd0, err_code}, 8'h00);

    // Reset between DATA and CHK, then the CHK byte alone is a bad CMD.
    send(8'h53); send(8'h22);
    @(negedge clk); #1; reset_n = 1'b0; rx_valid = 1'b0;
    @(negedge clk); #1;
    chk("midrst_sel", {6'd0, sel}, 8'h00);
    chk("midrst_data", data, 8'h00);
    chk("midrst_busy", {7'd0, busy}, 8'h00);
    reset_n = 1'b1;
    send(8'h71); cyc(1'b0, 8'h00);
    chk("midrst_err", {7'd0, err}, 8'h01);
    chk("midrst_code", {6'd0, err_code}, 8'h01);
    chk("midrst_busy2", {7'd0, busy}, 8'h00);

    // Randomized traffic.
    for (int f = 0; f < 300; f++) begin
      kind = $urandom_range(0, 9);
      c = {4'h5, 4'($urandom)};
      d = 8'($urandom);
      case (kind)
        0, 1, 2, 3, 4: begin
          send(c); gap($urandom_range(0, 2));
          send(d); gap($urandom_range(0, 2));
          send(c ^ d);
        end
        5: begin
          b = 8'($urandom);
          if (b == (c ^ d)) b = ~b;
          send(c); send(d); send(b);
        end
        6: begin
          b = 8'($urandom);
          if (b[7:4] == 4'h5) b = b ^ 8'h80;
          send(b);
        end
        7: begin
          send(c);
          if ($urandom_range(0, 1) == 1) send(d);
          gap($urandom_range(T - 2, T + 2));
        end
        8: begin
          send(c);
          if ($urandom_range(0, 1) == 1) send(d);
          pulse_reset();
        end
        default: send(8'($urandom));
      endcase
      gap($urandom_range(0, 3));
    end
    gap(T + 4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
